// File: rtl/tt_param_counter.sv
// Parametrised up/down counter with prescaler, wrap/saturate/ping-pong modes, tc pulse and sticky wrap flag.
// Latency: count and tc update on the rising edge after a tick; tc is aligned with the count value it marks.
// Backpressure: none; en gates the prescaler, and clr/load take priority over counting.
module tt_param_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  up,
    input  logic [WIDTH-1:0]      modulo,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  sticky_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  dir,
    output logic                  wrap_sticky
);

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    logic [PRESCALE_W-1:0] presc;
    logic                  dir_reg;
    // High until the first clocked cycle after reset, so ping-pong picks up 'up' at release.
    logic                  init_pending;
    logic                  tick;
    logic [WIDTH-1:0]      inc;
    logic [WIDTH-1:0]      dec;
    logic [WIDTH-1:0]      cnt_nxt;
    logic                  tc_nxt;
    logic                  dir_reg_nxt;

    assign tick = en && (presc == prescale);
    assign inc  = count + WIDTH'(1);
    assign dec  = count - WIDTH'(1);

    // Ping-pong uses the stored direction; every other mode follows 'up' directly.
    assign dir = (mode == MODE_PING && !init_pending) ? dir_reg : up;

    // Next count, terminal pulse and ping-pong direction for a tick in the current mode.
    always_comb begin
        cnt_nxt     = count;
        tc_nxt      = 1'b0;
        dir_reg_nxt = init_pending ? up : dir_reg;
        if (tick) begin
            case (mode)
                MODE_SAT: begin
                    if (dir) begin
                        if (count >= modulo) begin
                            cnt_nxt = modulo;
                        end else begin
                            cnt_nxt = inc;
                            tc_nxt  = (inc == modulo);
                        end
                    end else if (count != '0) begin
                        cnt_nxt = dec;
                        tc_nxt  = (dec == '0);
                    end
                end
                MODE_PING: begin
                    if (modulo == '0) begin
                        cnt_nxt     = '0;
                        dir_reg_nxt = ~dir;
                        tc_nxt      = 1'b1;
                    end else if (dir) begin
                        if (count > modulo) begin
                            cnt_nxt     = modulo;
                            dir_reg_nxt = 1'b0;
                            tc_nxt      = 1'b1;
                        end else if (count == modulo) begin
                            // Sitting on the terminal (after clr/load): turn round and step down.
                            cnt_nxt     = modulo - WIDTH'(1);
                            dir_reg_nxt = 1'b0;
                            tc_nxt      = 1'b1;
                        end else begin
                            cnt_nxt = inc;
                            if (inc == modulo) begin
                                dir_reg_nxt = 1'b0;
                                tc_nxt      = 1'b1;
                            end
                        end
                    end else begin
                        if (count == '0) begin
                            cnt_nxt     = WIDTH'(1);
                            dir_reg_nxt = 1'b1;
                            tc_nxt      = 1'b1;
                        end else begin
                            cnt_nxt = dec;
                            if (dec == '0) begin
                                dir_reg_nxt = 1'b1;
                                tc_nxt      = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // Wrap mode (00 and 11).
                    if (dir) begin
                        if (count >= modulo) begin
                            cnt_nxt = '0;
                            tc_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = inc;
                        end
                    end else begin
                        if (count == '0) begin
                            cnt_nxt = modulo;
                            tc_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = dec;
                        end
                    end
                end
            endcase
        end
    end

    // State registers: clr beats load beats tick; the sticky flag sees tc and lets a set win over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            tc           <= 1'b0;
            wrap_sticky  <= 1'b0;
            presc        <= '0;
            dir_reg      <= 1'b1;
            init_pending <= 1'b1;
        end else begin
            init_pending <= 1'b0;
            wrap_sticky  <= tc | (wrap_sticky & ~sticky_clr);
            if (clr) begin
                count   <= '0;
                presc   <= '0;
                dir_reg <= up;
                tc      <= 1'b0;
            end else if (load) begin
                count   <= load_val;
                presc   <= '0;
                dir_reg <= up;
                tc      <= 1'b0;
            end else begin
                count   <= cnt_nxt;
                tc      <= tc_nxt;
                dir_reg <= dir_reg_nxt;
                if (en) begin
                    presc <= tick ? '0 : presc + PRESCALE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_param_counter.sv
// Directed bench for tt_param_counter: expected states queued as stimulus is driven, compared after each edge.
// Latency: every compare samples 1 ns after the rising edge.
// Backpressure: none; the bench runs a fixed cycle count and always terminates.
module tb_tt_param_counter;

    localparam int W  = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic          load;
    logic [W-1:0]  load_val;
    logic          up;
    logic [W-1:0]  modulo;
    logic [1:0]    mode;
    logic [PW-1:0] prescale;
    logic          sticky_clr;
    logic [W-1:0]  count;
    logic          tc;
    logic          dir;
    logic          wrap_sticky;

    typedef struct packed {
        logic [W-1:0] c;
        logic         t;
        logic         d;
        logic         s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    tt_param_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .load        (load),
        .load_val    (load_val),
        .up          (up),
        .modulo      (modulo),
        .mode        (mode),
        .prescale    (prescale),
        .sticky_clr  (sticky_clr),
        .count       (count),
        .tc          (tc),
        .dir         (dir),
        .wrap_sticky (wrap_sticky)
    );

    always #5 clk = ~clk;

    task automatic exp_push(input logic [W-1:0] c, input logic t, input logic d, input logic s);
        exp_t e;
        e.c = c;
        e.t = t;
        e.d = d;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL %s: scoreboard empty, observed count %0d, expected an entry", tag, count);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (count === e.c) passes++;
            else $error("FAIL %s count: observed %0d expected %0d", tag, count, e.c);
            checks++;
            assert (tc === e.t) passes++;
            else $error("FAIL %s tc: observed %b expected %b", tag, tc, e.t);
            checks++;
            assert (dir === e.d) passes++;
            else $error("FAIL %s dir: observed %b expected %b", tag, dir, e.d);
            checks++;
            assert (wrap_sticky === e.s) passes++;
            else $error("FAIL %s wrap_sticky: observed %b expected %b", tag, wrap_sticky, e.s);
        end
    endtask

    task automatic cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            compare(tag);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        up         = 1'b1;
        modulo     = 4'd9;
        mode       = 2'b00;
        prescale   = '0;
        sticky_clr = 1'b0;

        #12;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        compare("reset");

        // Wrap up to 9 and back round.
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            exp_push(4'(i % 10), (i % 10) == 0, 1'b1, i >= 11);
        end
        cycles(12, "wrap_up");

        // Load 2 and wrap downward; sticky clear coinciding with tc loses.
        up       = 1'b0;
        load     = 1'b1;
        load_val = 4'd2;
        exp_push(4'd2, 1'b0, 1'b0, 1'b1);
        cycles(1, "load_dn");
        load = 1'b0;
        exp_push(4'd1, 1'b0, 1'b0, 1'b1);
        exp_push(4'd0, 1'b0, 1'b0, 1'b1);
        exp_push(4'd9, 1'b1, 1'b0, 1'b1);
        cycles(3, "wrap_dn");
        sticky_clr = 1'b1;
        exp_push(4'd8, 1'b0, 1'b0, 1'b1);
        cycles(1, "set_wins");
        sticky_clr = 1'b0;
        exp_push(4'd7, 1'b0, 1'b0, 1'b1);
        cycles(1, "sticky_hold");
        sticky_clr = 1'b1;
        exp_push(4'd6, 1'b0, 1'b0, 1'b0);
        cycles(1, "sticky_clr");
        sticky_clr = 1'b0;

        // Saturate up to 5, then down to 0.
        mode     = 2'b01;
        modulo   = 4'd5;
        up       = 1'b1;
        load     = 1'b1;
        load_val = 4'd3;
        exp_push(4'd3, 1'b0, 1'b1, 1'b0);
        cycles(1, "sat_load");
        load = 1'b0;
        exp_push(4'd4, 1'b0, 1'b1, 1'b0);
        exp_push(4'd5, 1'b1, 1'b1, 1'b0);
        exp_push(4'd5, 1'b0, 1'b1, 1'b1);
        exp_push(4'd5, 1'b0, 1'b1, 1'b1);
        exp_push(4'd5, 1'b0, 1'b1, 1'b1);
        cycles(5, "sat_up");
        up = 1'b0;
        exp_push(4'd4, 1'b0, 1'b0, 1'b1);
        exp_push(4'd3, 1'b0, 1'b0, 1'b1);
        exp_push(4'd2, 1'b0, 1'b0, 1'b1);
        exp_push(4'd1, 1'b0, 1'b0, 1'b1);
        exp_push(4'd0, 1'b1, 1'b0, 1'b1);
        exp_push(4'd0, 1'b0, 1'b0, 1'b1);
        exp_push(4'd0, 1'b0, 1'b0, 1'b1);
        cycles(7, "sat_dn");

        // Ping-pong over 0..3; 'up' is ignored once the direction is latched.
        mode       = 2'b10;
        modulo     = 4'd3;
        up         = 1'b1;
        clr        = 1'b1;
        sticky_clr = 1'b1;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        cycles(1, "pp_clr");
        clr        = 1'b0;
        sticky_clr = 1'b0;
        up         = 1'b0;
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        exp_push(4'd2, 1'b0, 1'b1, 1'b0);
        exp_push(4'd3, 1'b1, 1'b0, 1'b0);
        exp_push(4'd2, 1'b0, 1'b0, 1'b1);
        exp_push(4'd1, 1'b0, 1'b0, 1'b1);
        exp_push(4'd0, 1'b1, 1'b1, 1'b1);
        exp_push(4'd1, 1'b0, 1'b1, 1'b1);
        exp_push(4'd2, 1'b0, 1'b1, 1'b1);
        cycles(8, "pingpong");

        // Prescaler of 3 with en dropped for two cycles mid-period.
        mode       = 2'b00;
        up         = 1'b1;
        modulo     = 4'd9;
        prescale   = 4'd2;
        clr        = 1'b1;
        sticky_clr = 1'b1;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        cycles(1, "ps_clr");
        clr        = 1'b0;
        sticky_clr = 1'b0;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        cycles(4, "ps_run");
        en = 1'b0;
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        cycles(2, "ps_hold");
        en = 1'b1;
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        exp_push(4'd2, 1'b0, 1'b1, 1'b0);
        cycles(2, "ps_resume");

        // Load above modulo, then wrap on the next tick.
        prescale = '0;
        load     = 1'b1;
        load_val = 4'd12;
        exp_push(4'd12, 1'b0, 1'b1, 1'b0);
        cycles(1, "over_load");
        load = 1'b0;
        exp_push(4'd0, 1'b1, 1'b1, 1'b0);
        exp_push(4'd1, 1'b0, 1'b1, 1'b1);
        cycles(2, "over_wrap");

        // Mode 11 behaves as wrap, counting down.
        mode = 2'b11;
        up   = 1'b0;
        exp_push(4'd0, 1'b0, 1'b0, 1'b1);
        exp_push(4'd9, 1'b1, 1'b0, 1'b1);
        cycles(2, "mode11");

        // Asynchronous reset mid-count, away from any edge.
        #3;
        up    = 1'b1;
        rst_n = 1'b0;
        #1;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        compare("async_rst");

        // clr and load together: clr wins.
        rst_n    = 1'b1;
        mode     = 2'b00;
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 4'd7;
        exp_push(4'd0, 1'b0, 1'b1, 1'b0);
        cycles(1, "clr_load");
        clr  = 1'b0;
        load = 1'b0;
        exp_push(4'd1, 1'b0, 1'b1, 1'b0);
        cycles(1, "after_clr");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
